// File: rtl/inv_shift_mix.sv
// inv_shift_mix: AES InvShiftRows then column-serial InvMixColumns (skippable for the final round).
module inv_shift_mix (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);
  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [0:127] w_q, w_d;
  logic         init_q;
  logic [7:0]   mixed [4];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction
  // InvMixColumns matrix is circulant: row r uses coef[(j-r) mod 4] on input byte j
  function automatic logic [3:0] coef(input int d);
    return d == 0 ? 4'he : d == 1 ? 4'hb : d == 2 ? 4'hd : 4'h9;
  endfunction
  function automatic logic [0:127] isr(input logic [0:127] s);
    logic [0:127] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(4*r+c) +: 8] = s[8*(4*r+((c-r)&3)) +: 8];
    return o;
  endfunction
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 4; j++)
        acc = acc ^ gm(w_q[8*(4*j+int'(col_q)) +: 8], coef((j-r)&3));
      mixed[r] = acc;
    end
  end
  assign in_ready  = init_q && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_state = w_q;
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    w_d     = w_q;
    if (state_q == IDLE && in_valid && in_ready) begin
      w_d     = isr(in_state);
      col_d   = 2'd0;
      state_d = in_skip_mix ? DONE : MIX;
    end else if (state_q == MIX) begin
      for (int r = 0; r < 4; r++) w_d[8*(4*r+int'(col_q)) +: 8] = mixed[r];
      col_d   = col_q + 2'd1;
      state_d = col_q == 2'd3 ? DONE : MIX;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // init_q holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      w_q     <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      w_q     <= w_d;
      init_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inv_shift_mix.sv
// tb_inv_shift_mix: directed + random checks of inv_shift_mix against a byte-array AES reference model.
module tb_inv_shift_mix;
  logic         clk = 0, rst_n = 0, in_valid = 0, in_skip_mix = 0, out_ready = 0;
  logic         in_ready, out_valid;
  logic [0:127] in_state = '0, out_state;
  int vectors = 0, errs = 0;
  localparam logic [7:0] M [16] = '{8'h0e,8'h0b,8'h0d,8'h09, 8'h09,8'h0e,8'h0b,8'h0d,
                                    8'h0d,8'h09,8'h0e,8'h0b, 8'h0b,8'h0d,8'h09,8'h0e};
  inv_shift_mix dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_skip_mix(in_skip_mix), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state));
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [0:127] model(input logic [0:127] s, input logic skip);
    logic [7:0] x [16];
    logic [7:0] t [16];
    logic [7:0] y [16];
    logic [0:127] o;
    for (int i = 0; i < 16; i++) x[i] = s[8*i +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[4*r+c] = x[4*r + (c - r + 4) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        y[4*r+c] = 8'h00;
        for (int j = 0; j < 4; j++) y[4*r+c] = y[4*r+c] ^ gmul(M[4*r+j], t[4*j+c]);
      end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = skip ? t[i] : y[i];
    return o;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic disturb();
    in_state    = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_skip_mix = 1'($urandom());
  endtask
  task automatic run(input logic [0:127] s, input logic skip, input int hold, output logic [0:127] got);
    logic [0:127] exp, held;
    exp = model(s, skip);
    @(negedge clk);
    chk("ready_idle", 128'(in_ready), 128'(1));
    in_valid = 1; in_state = s; in_skip_mix = skip;
    @(negedge clk);
    in_valid = 0;
    disturb();
    for (int k = 1; k < (skip ? 1 : 5); k++) begin
      chk("busy_valid", 128'(out_valid), 128'(0));
      chk("busy_ready", 128'(in_ready), 128'(0));
      disturb();
      @(negedge clk);
    end
    chk("done_valid", 128'(out_valid), 128'(1));
    chk("result", out_state, exp);
    got  = out_state;
    held = out_state;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1;
      disturb();
      @(negedge clk);
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_state", out_state, held);
      chk("hold_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1; in_valid = 1;
    @(negedge clk);
    chk("release_valid", 128'(out_valid), 128'(0));
    chk("release_ready", 128'(in_ready), 128'(1));
    chk("release_state", out_state, held);
    out_ready = 0; in_valid = 0;
  endtask
  initial begin
    logic [0:127] got, v;
    @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_state", out_state, 128'(0));
    rst_n = 1;
    #1 chk("ready_before_edge", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_edge", 128'(in_ready), 128'(1));
    v = 128'h000102030405060708090a0b0c0d0e0f;
    run(v, 1'b1, 0, got);
    chk("kat_skip", got, 128'h00010203070405060a0b08090d0e0f0c);
    v = 128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc;
    run(v, 1'b0, 0, got);
    chk("kat_mix", got, 128'hdbdbdbdb131313135353535345454545);
    v = {16{8'h01}};
    run(v, 1'b0, 0, got);
    chk("ident_01", got, v);
    v = {16{8'hc6}};
    run(v, 1'b0, 10, got);
    chk("ident_c6", got, v);
    // abort while col=2 is the next column to mix
    @(negedge clk);
    in_valid = 1; in_state = {$urandom(), $urandom(), $urandom(), $urandom()}; in_skip_mix = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_valid", 128'(out_valid), 128'(0));
    chk("abort_ready", 128'(in_ready), 128'(0));
    chk("abort_state", out_state, 128'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    v = 128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc;
    run(v, 1'b0, 2, got);
    chk("post_abort_kat", got, 128'hdbdbdbdb131313135353535345454545);
    for (int n = 0; n < 12; n++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      run(v, 1'($urandom()), int'($urandom_range(0, 3)), got);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
